// File: rtl/score_pkg.sv
// Shared types and sizing helpers for the BCD score counters.
package score_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam int NUM_PLAYERS_DEF = 2;
  localparam int DIGITS_DEF      = 2;
  localparam int WIN_LO_DEF      = 11;
  localparam int WIN_HI_DEF      = 15;
  localparam int HOLD_CYCLES_DEF = 1024;

  function automatic int max_score(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

  function automatic int cnt_w(input int digits);
    return $clog2(max_score(digits) + 1);
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Saturating multi-digit BCD score counter with a binary shadow used for limit compares.
module bcd_score_counter
  import score_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                     clk,
  input  logic                     _rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [DIGITS*4-1:0]      bcd,
  output logic [cnt_w(DIGITS)-1:0] bin,
  output logic                     sat
);

  localparam int            CW  = cnt_w(DIGITS);
  localparam logic [CW-1:0] MAX = CW'(max_score(DIGITS));

  logic [DIGITS*4-1:0] r_bcd;
  logic [CW-1:0]       r_bin;
  logic [DIGITS*4-1:0] w_bcd_inc;
  logic                w_carry;
  logic                w_sat;

  assign w_sat = (r_bin == MAX);

  // Ripple a carry up through the digits; a digit at 9 rolls to 0 and passes it on.
  always_comb begin
    w_carry   = 1'b1;
    w_bcd_inc = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_carry) begin
        if (r_bcd[d*4 +: 4] == 4'd9) begin
          w_bcd_inc[d*4 +: 4] = 4'd0;
        end else begin
          w_bcd_inc[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd1;
          w_carry             = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_bcd <= '0;
      r_bin <= '0;
    end else if (clr) begin
      r_bcd <= '0;
      r_bin <= '0;
    end else if (inc && !w_sat) begin
      r_bcd <= w_bcd_inc;
      r_bin <= r_bin + CW'(1);
    end
  end

  assign bcd = r_bcd;
  assign bin = r_bin;
  assign sat = w_sat;

endmodule

// File: rtl/score_counters_n.sv
// N-player Pong score keeper: edge detect, priority select, hold-off FSM and win compare.
// Optional SCORE_WIN_BY_TWO_EN: a win also needs a 2-point lead (or a saturated score).
module score_counters_n
  import score_pkg::*;
#(
  parameter int NUM_PLAYERS = NUM_PLAYERS_DEF,
  parameter int DIGITS      = DIGITS_DEF,
  parameter int WIN_LO      = WIN_LO_DEF,
  parameter int WIN_HI      = WIN_HI_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic                                                   clk,
  input  logic                                                   _rst,
  input  logic                                                   srst,
  input  logic                                                   _attract,
  input  logic                                                   win_sel,
  input  logic [NUM_PLAYERS-1:0]                                 point,
  output logic [NUM_PLAYERS*DIGITS*4-1:0]                        score_bcd,
  output logic                                                   _miss,
  output logic                                                   stop_g,
  output logic [((NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1)-1:0] winner
);

  localparam int          WW     = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int          CW     = cnt_w(DIGITS);
  localparam int          HW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [31:0] LIM_LO = 32'(WIN_LO);
  localparam logic [31:0] LIM_HI = 32'(WIN_HI);
`ifdef SCORE_WIN_BY_TWO_EN
  localparam logic [31:0] MAXS   = 32'(max_score(DIGITS));
`endif

  state_e                 r_state, w_state_nxt;
  logic [NUM_PLAYERS-1:0] r_point_q;
  logic [NUM_PLAYERS-1:0] w_edge, w_first, w_inc;
  logic [HW-1:0]          r_hold, w_hold_nxt;
  logic                   r_miss, w_miss_nxt;
  logic                   r_stop, w_stop_nxt;
  logic [WW-1:0]          r_winner, w_winner_nxt;
  logic [WW-1:0]          w_sel;
  logic                   w_any, w_clr, w_win;
  logic [31:0]            w_new, w_limit;
  logic [CW-1:0]          w_bin [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] w_sat;
`ifdef SCORE_WIN_BY_TWO_EN
  logic                   w_lead2;
`endif

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ctr
    bcd_score_counter #(
      .DIGITS (DIGITS)
    ) u_ctr (
      .clk  (clk),
      ._rst (_rst),
      .clr  (w_clr),
      .inc  (w_inc[p]),
      .bcd  (score_bcd[p*DIGITS*4 +: DIGITS*4]),
      .bin  (w_bin[p]),
      .sat  (w_sat[p])
    );
  end

  assign w_edge  = point & ~r_point_q;
  assign w_first = w_edge & (~w_edge + NUM_PLAYERS'(1));
  assign w_limit = win_sel ? LIM_HI : LIM_LO;

  // Scanning downward leaves the lowest-index edged player as the winner of the tie.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_new = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      if (w_edge[p]) begin
        w_any = 1'b1;
        w_sel = WW'(p);
        w_new = w_sat[p] ? 32'(w_bin[p]) : 32'(w_bin[p]) + 32'd1;
      end
    end
  end

  always_comb begin
    w_win = (w_new >= w_limit);
`ifdef SCORE_WIN_BY_TWO_EN
    w_lead2 = 1'b1;
    for (int q = 0; q < NUM_PLAYERS; q++) begin
      if ((WW'(q) != w_sel) && ((32'(w_bin[q]) + 32'd2) > w_new)) w_lead2 = 1'b0;
    end
    w_win = w_win && (w_lead2 || (w_new == MAXS));
`endif
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold;
    w_miss_nxt   = 1'b1;
    w_stop_nxt   = r_stop;
    w_winner_nxt = r_winner;
    w_inc        = '0;
    w_clr        = 1'b0;
    if (srst) begin
      w_clr        = 1'b1;
      w_state_nxt  = PLAY;
      w_hold_nxt   = '0;
      w_stop_nxt   = 1'b0;
      w_winner_nxt = '0;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_any) begin
            w_miss_nxt  = 1'b0;
            w_state_nxt = HOLD;
            w_hold_nxt  = HW'(HOLD_CYCLES - 1);
            if (_attract) begin
              w_inc = w_first;
              if (w_win) begin
                w_state_nxt  = OVER;
                w_hold_nxt   = '0;
                w_stop_nxt   = 1'b1;
                w_winner_nxt = w_sel;
              end
            end
          end
        end
        HOLD: begin
          if (r_hold == '0) w_state_nxt = PLAY;
          else              w_hold_nxt  = r_hold - HW'(1);
        end
        OVER:    ;
        default: w_state_nxt = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state   <= PLAY;
      r_point_q <= '0;
      r_hold    <= '0;
      r_miss    <= 1'b1;
      r_stop    <= 1'b0;
      r_winner  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_point_q <= point;
      r_hold    <= w_hold_nxt;
      r_miss    <= w_miss_nxt;
      r_stop    <= w_stop_nxt;
      r_winner  <= w_winner_nxt;
    end
  end

  assign _miss  = r_miss;
  assign stop_g = r_stop;
  assign winner = r_winner;

endmodule

// File: tb/tb_score_counters_n.sv
// Randomized bench for score_counters_n against a per-point behavioural model (two configurations).
module tb_score_counters_n;

  localparam int HC_A = 20;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        srst = 1'b0;
  logic        attract = 1'b1;
  logic        win_sel = 1'b0;
  logic [1:0]  point_a = '0;
  logic [2:0]  point_b = '0;
  logic [15:0] score_a;
  logic [2:0]  score_b_unused_guard;
  logic [11:0] score_b;
  logic        miss_a, miss_b, stop_a, stop_b;
  logic        win_a;
  logic [1:0]  win_b;

  int n_chk = 0;
  int n_fail = 0;
  int n_miss_a = 0;

  int m_score [2][8];
  int m_prev  [2];
  bit m_over  [2];
  int m_hold  [2];
  bit m_miss  [2];
  int m_win   [2];

  always #5 clk = ~clk;
  assign score_b_unused_guard = '0;

  score_counters_n #(
    .NUM_PLAYERS(2), .DIGITS(2), .WIN_LO(11), .WIN_HI(15), .HOLD_CYCLES(HC_A)
  ) dut_a (
    .clk(clk), ._rst(n_rst), .srst(srst), ._attract(attract), .win_sel(win_sel),
    .point(point_a), .score_bcd(score_a), ._miss(miss_a), .stop_g(stop_a), .winner(win_a)
  );

  score_counters_n #(
    .NUM_PLAYERS(3), .DIGITS(1), .WIN_LO(15), .WIN_HI(15), .HOLD_CYCLES(1)
  ) dut_b (
    .clk(clk), ._rst(n_rst), .srst(srst), ._attract(attract), .win_sel(win_sel),
    .point(point_b), .score_bcd(score_b), ._miss(miss_b), .stop_g(stop_b), .winner(win_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int bcd_of(input int v, input int digits);
    int r, x;
    r = 0;
    x = v;
    for (int d = 0; d < digits; d++) begin
      r = r | ((x % 10) << (4 * d));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_score[k][i] = 0;
      m_prev[k] = 0; m_over[k] = 0; m_hold[k] = 0; m_miss[k] = 1; m_win[k] = 0;
    end
  endtask

  // One clock of game rules: a point is taken only while playing, not held off and not over.
  task automatic model_step(input int k, input int np, input int mx, input int hc,
                            input int lo, input int hi, input int pt,
                            input bit sr, input bit at, input bit ws);
    int edg, lim, s, p;
    bit won;
    edg = pt & ~m_prev[k];
    m_prev[k] = pt;
    m_miss[k] = 1;
    if (sr) begin
      for (int i = 0; i < 8; i++) m_score[k][i] = 0;
      m_over[k] = 0; m_win[k] = 0; m_hold[k] = 0;
    end else if (m_over[k]) begin
    end else if (m_hold[k] > 0) begin
      m_hold[k]--;
    end else if (edg != 0) begin
      p = 0;
      while (((edg >> p) & 1) == 0) p++;
      m_miss[k] = 0;
      m_hold[k] = hc;
      if (at) begin
        s = (m_score[k][p] < mx) ? m_score[k][p] + 1 : mx;
        m_score[k][p] = s;
        lim = ws ? hi : lo;
        won = (s >= lim);
`ifdef SCORE_WIN_BY_TWO_EN
        if (won && s != mx) begin
          for (int q = 0; q < np; q++)
            if (q != p && m_score[k][q] + 2 > s) won = 0;
        end
`endif
        if (won) begin
          m_over[k] = 1; m_win[k] = p; m_hold[k] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] ea, eb;
    ea = 32'(bcd_of(m_score[0][0], 2)) | (32'(bcd_of(m_score[0][1], 2)) << 8);
    eb = '0;
    for (int i = 0; i < 3; i++) eb = eb | (32'(bcd_of(m_score[1][i], 1)) << (4 * i));
    check("a_score", 32'(score_a), ea);
    check("a_miss", 32'(miss_a), 32'(m_miss[0]));
    check("a_stop", 32'(stop_a), 32'(m_over[0]));
    check("a_winner", 32'(win_a), 32'(m_win[0]));
    check("b_score", 32'(score_b), eb);
    check("b_miss", 32'(miss_b), 32'(m_miss[1]));
    check("b_stop", 32'(stop_b), 32'(m_over[1]));
    check("b_winner", 32'(win_b), 32'(m_win[1]));
  endtask

  task automatic tick();
    logic [1:0] pa;
    logic [2:0] pb;
    bit sr, at, ws;
    pa = point_a; pb = point_b; sr = srst; at = attract; ws = win_sel;
    @(posedge clk);
    model_step(0, 2, 99, HC_A, 11, 15, int'(pa), sr, at, ws);
    model_step(1, 3, 9, 1, 15, 15, int'(pb), sr, at, ws);
    #1;
    compare_all();
    if (!miss_a) n_miss_a++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_a(input logic [1:0] v);
    point_a = v;
    tick();
    point_a = '0;
    tick();
  endtask

  task automatic pulse_b(input logic [2:0] v);
    point_b = v;
    tick();
    point_b = '0;
    tick();
  endtask

  initial begin
    int m0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check("rst_score_a", 32'(score_a), 32'h0);
    check("rst_miss_a", 32'(miss_a), 32'h1);
    n_rst = 1'b1;

    // first point for player 0
    point_a = 2'b01;
    tick();
    check("p0_miss_low", 32'(miss_a), 32'h0);
    check("p0_score", 32'(score_a[7:0]), 32'h01);
    point_a = 2'b00;
    tick();
    check("p0_miss_high", 32'(miss_a), 32'h1);

    pulse_a(2'b10);
    check("hold_ignored", 32'(score_a[15:8]), 32'h00);
    idle(HC_A + 5);
    pulse_a(2'b10);
    check("after_hold_p1", 32'(score_a[15:8]), 32'h01);
    idle(HC_A + 5);
    pulse_a(2'b11);
    check("simul_edges", 32'(score_a), 32'h0102);
    idle(HC_A + 2);

    for (int i = 0; i < 10; i++) begin
      pulse_a(2'b10);
      idle(HC_A + 2);
    end
    check("win_score", 32'(score_a), 32'h1102);
    check("win_stop", 32'(stop_a), 32'h1);
    check("win_idx", 32'(win_a), 32'h1);
    pulse_a(2'b10);
    pulse_a(2'b01);
    check("over_frozen", 32'(score_a), 32'h1102);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check("srst_score", 32'(score_a), 32'h0);
    check("srst_stop", 32'(stop_a), 32'h0);

    attract = 1'b0;
    m0 = n_miss_a;
    for (int i = 0; i < 5; i++) begin
      pulse_a(2'b01);
      idle(HC_A + 2);
    end
    check("attract_misses", 32'(n_miss_a - m0), 32'd5);
    check("attract_score", 32'(score_a), 32'h0);
    check("attract_stop", 32'(stop_a), 32'h0);
    attract = 1'b1;

`ifdef SCORE_WIN_BY_TWO_EN
    for (int i = 0; i < 10; i++) begin
      pulse_a(2'b01); idle(HC_A + 2);
      pulse_a(2'b10); idle(HC_A + 2);
    end
    pulse_a(2'b01); idle(HC_A + 2);
    check("deuce_11_10", 32'(score_a), 32'h1011);
    check("deuce_stop", 32'(stop_a), 32'h0);
    pulse_a(2'b01); idle(HC_A + 2);
    check("lead2_score", 32'(score_a), 32'h1012);
    check("lead2_stop", 32'(stop_a), 32'h1);
    check("lead2_winner", 32'(win_a), 32'h0);
    srst = 1'b1; tick(); srst = 1'b0;
`endif

    for (int i = 0; i < 12; i++) begin
      pulse_b(3'b001);
      idle(1);
    end
    check("sat_score", 32'(score_b[3:0]), 32'h9);
    check("sat_stop", 32'(stop_b), 32'h0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(3) == 0) point_a = 2'($urandom);
      if ($urandom_range(2) == 0) point_b = 3'($urandom);
      srst = ($urandom_range(149) == 0);
      if ($urandom_range(39) == 0) attract = ~attract;
      if ($urandom_range(59) == 0) win_sel = ~win_sel;
      tick();
    end
    srst = 1'b0;
    attract = 1'b1;

    // asynchronous reset taken between clock edges
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    #1;
    n_rst = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(3) == 0) point_a = 2'($urandom);
      if ($urandom_range(2) == 0) point_b = 3'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
